// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared types and width helpers for the message assembler
package msg_pkg;

    typedef logic [7:0] byte_t;

    // Assembler FSM: collecting bytes, or holding a complete message.
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    // Width of the write index into a MSG_LEN-byte buffer (at least 1 bit).
    function automatic int cnt_width(input int msg_len);
        return (msg_len > 1) ? $clog2(msg_len) : 1;
    endfunction

    // Width of a byte count that must reach MSG_LEN itself.
    function automatic int len_width(input int msg_len);
        return (msg_len > 0) ? $clog2(msg_len + 1) : 1;
    endfunction

endpackage

// File: rtl/msg_assembler.sv
// rtl/msg_assembler.sv - collects a byte stream into fixed-length messages
//
// Purpose: gathers MSG_LEN upstream bytes into msg_out and holds the message
// until downstream takes it. One bubble cycle separates consecutive messages.
// Optional feature macro: MSG_PAD_EN - a byte with in_last closes the message
// early, filling the unwritten tail with PAD_BYTE and reporting the short
// length on msg_len. Without it, in_last is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream byte valid
//   in_ready   byte accepted this cycle (FILL and not in reset)
//   in_data    upstream byte
//   in_last    final byte of a short message (MSG_PAD_EN only)
//   msg_out    assembled message, byte 0 first received
//   msg_valid  msg_out holds a complete message
//   msg_ready  downstream consumes the held message
//   msg_len    number of real (non-pad) bytes in msg_out
module msg_assembler
    import msg_pkg::*;
#(
    parameter int    MSG_LEN  = 9,
    parameter byte_t PAD_BYTE = 8'h00
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [7:0]                       in_data,
    input  logic                             in_last,
    output byte_t                            msg_out [0:MSG_LEN-1],
    output logic                             msg_valid,
    input  logic                             msg_ready,
    output logic [$clog2(MSG_LEN+1)-1:0]     msg_len
);

    localparam int CW = cnt_width(MSG_LEN);
    localparam int LW = len_width(MSG_LEN);

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    byte_t           r_buf [0:MSG_LEN-1];
    logic [LW-1:0]   r_len;

    logic            w_xfer;
    logic            w_last_byte;
    logic            w_close;

    assign in_ready    = (r_state == ST_FILL) && !rst;
    assign w_xfer      = in_valid && in_ready;
    assign w_last_byte = (r_cnt == CW'(MSG_LEN - 1));

`ifdef MSG_PAD_EN
    // A flagged last byte closes the message early; on the final slot it is
    // indistinguishable from a normal full message.
    assign w_close = w_last_byte || in_last;
`else
    logic w_unused_in_last;
    assign w_unused_in_last = in_last;
    assign w_close          = w_last_byte;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_len   <= '0;
            for (int i = 0; i < MSG_LEN; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_xfer) begin
                        // Slots above the write index keep their old content
                        // unless the message is being closed with padding.
                        for (int i = 0; i < MSG_LEN; i++) begin
                            if (CW'(i) == r_cnt) begin
                                r_buf[i] <= in_data;
                            end
`ifdef MSG_PAD_EN
                            else if (in_last && (CW'(i) > r_cnt)) begin
                                r_buf[i] <= PAD_BYTE;
                            end
`endif
                        end
                        if (w_close) begin
                            // The index is left in place; it is cleared when
                            // the message is released.
                            r_state <= ST_FULL;
                            r_len   <= LW'(r_cnt) + LW'(1);
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_FULL: begin
                    // Release costs one cycle: in_ready only rises once the
                    // FSM is back in FILL, giving the inter-message bubble.
                    if (msg_ready) begin
                        r_state <= ST_FILL;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign msg_out   = r_buf;
    assign msg_valid = (r_state == ST_FULL);
    assign msg_len   = r_len;

endmodule

// File: tb/tb_msg_assembler.sv
// tb/tb_msg_assembler.sv - self-checking bench for msg_assembler
module tb_msg_assembler;
    import msg_pkg::*;

    localparam int N = 9;
`ifdef MSG_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  in_valid = 1'b0;
    logic  in_last = 1'b0;
    logic  msg_ready = 1'b0;
    byte_t in_data = 8'h00;
    logic  in_ready;
    logic  msg_valid;
    byte_t msg_out [0:N-1];
    logic  [3:0] msg_len;

    int checks = 0;
    int errors = 0;

    // Reference model: message state as the requirements describe it.
    bit    m_full;
    int    m_cnt;
    int    m_len;
    byte_t m_buf [N];

    bit seen_ready;
    bit seen_valid;

    msg_assembler #(.MSG_LEN(N), .PAD_BYTE(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .msg_out   (msg_out),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_len   (msg_len)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_cnt  = 0;
        m_len  = 0;
        for (int i = 0; i < N; i++) m_buf[i] = 8'h00;
    endtask

    // One clock: drive inputs, compare every output at the falling edge,
    // then advance the model by what the rising edge transfers.
    task automatic cycle(input logic v, input byte_t d, input logic l,
                         input logic mr, input logic r, output bit acc);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        msg_ready = mr;
        rst       = r;
        @(negedge clk);
        seen_ready = in_ready;
        seen_valid = msg_valid;
        check("in_ready", {31'b0, in_ready}, {31'b0, (!m_full && !r)});
        check("msg_valid", {31'b0, msg_valid}, {31'b0, m_full});
        check("msg_len", {28'b0, msg_len}, m_len);
        for (int i = 0; i < N; i++)
            check($sformatf("msg_out[%0d]", i), {24'b0, msg_out[i]}, {24'b0, m_buf[i]});
        @(posedge clk);
        acc = !r && !m_full && v;
        if (r) begin
            model_reset();
        end else if (!m_full) begin
            if (v) begin
                m_buf[m_cnt] = d;
                if (m_cnt == N - 1 || (PAD && l)) begin
                    for (int j = m_cnt + 1; j < N; j++) m_buf[j] = 8'h00;
                    m_len  = m_cnt + 1;
                    m_full = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end else if (mr) begin
            m_full = 1'b0;
            m_cnt  = 0;
        end
        #1;
    endtask

    initial begin
        bit    acc;
        string s1;
        int    sent;
        int    valid_cycles;
        int    low_between;

        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        check("rst_valid", {31'b0, msg_valid}, 32'd0);
        check("rst_len", {28'b0, msg_len}, 32'd0);
        check("rst_byte0", {24'b0, msg_out[0]}, 32'd0);

        // Streamed 9-byte message held with msg_ready low.
        s1 = "AAABBBCCC";
        for (int i = 0; i < N; i++) cycle(1'b1, byte_t'(s1[i]), 1'b0, 1'b0, 1'b0, acc);
        check("s1_valid", {31'b0, msg_valid}, 32'd1);
        check("s1_len", {28'b0, msg_len}, 32'd9);
        for (int i = 0; i < N; i++)
            check($sformatf("s1_byte%0d", i), {24'b0, msg_out[i]}, {24'b0, s1[i]});

        // Hold for 5 cycles with upstream still offering bytes.
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, byte_t'($urandom), 1'b0, 1'b0, 1'b0, acc);
            check("s2_ready_low", {31'b0, seen_ready}, 32'd0);
        end
        for (int i = 0; i < N; i++)
            check($sformatf("s2_hold%0d", i), {24'b0, msg_out[i]}, {24'b0, s1[i]});
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, acc);
        check("s2_bubble", {31'b0, seen_ready}, 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        check("s2_refill", {31'b0, seen_ready}, 32'd1);

        // Partial message discarded by reset.
        for (int k = 0; k < 4; k++) cycle(1'b1, byte_t'($urandom), 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, acc);
        for (int k = 0; k < N; k++) cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, acc);
        check("s3_valid", {31'b0, msg_valid}, 32'd1);
        for (int i = 0; i < N; i++)
            check($sformatf("s3_byte%0d", i), {24'b0, msg_out[i]}, 32'h5A);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);

        // msg_ready tied high, 18 back-to-back bytes.
        sent = 0;
        valid_cycles = 0;
        low_between = 0;
        for (int k = 0; k < 40 && sent < 18; k++) begin
            cycle(1'b1, byte_t'(sent + 8'h10), 1'b0, 1'b1, 1'b0, acc);
            if (seen_valid) valid_cycles++;
            if (!seen_ready && sent >= 9 && sent < 18) low_between++;
            if (acc) sent++;
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
        if (seen_valid) valid_cycles++;
        check("s5_sent", sent, 32'd18);
        check("s5_valid_cycles", valid_cycles, 32'd2);
        check("s5_bubble", low_between, 32'd1);

`ifdef MSG_PAD_EN
        // Short message closed by in_last.
        cycle(1'b1, 8'h48, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h49, 1'b1, 1'b0, 1'b0, acc);
        check("s4_valid", {31'b0, msg_valid}, 32'd1);
        check("s4_len", {28'b0, msg_len}, 32'd2);
        check("s4_b0", {24'b0, msg_out[0]}, 32'h48);
        check("s4_b1", {24'b0, msg_out[1]}, 32'h49);
        for (int i = 2; i < N; i++)
            check($sformatf("s4_pad%0d", i), {24'b0, msg_out[i]}, 32'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(3, 0) != 0), byte_t'($urandom),
                  ($urandom_range(5, 0) == 0), ($urandom_range(1, 0) == 1),
                  ($urandom_range(63, 0) == 0), acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
